fb_plotter: RTL and testbench

Write-side engine for the 320x180 RGB565 frame buffer: owns port A of the dual-port frame-buffer RAM, while the HDMI scan-out path owns port B read-only. At each frame start it sweeps the buffer to a clear colour, then accepts a valid/ready stream of integer screen coordinates with colours from the position-transform stage. It converts each in-bounds point to a linear address, issues one registered write, and counts dropped off-screen points.

---
 rtl/fb_plotter.sv | 175 +++++++++++++++++
 tb/tb_fb_plotter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_plotter.sv
`default_nettype none
// ============================================================================
// Module   : fb_plotter
// Purpose  : Port-A write engine for the RGB565 frame buffer. It sweeps the
//            buffer to a clear colour, then plots streamed points. Building
//            with FB_PLOT_CLEAR_EN enables the per-frame clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module fb_plotter #(
  parameter int          FB_WIDTH    = 320,
  parameter int          FB_HEIGHT   = 180,
  parameter int          ADDR_W      = 16,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start_in,
  input  logic [15:0]       x_in,
  input  logic [15:0]       y_in,
  input  logic [15:0]       color_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [ADDR_W-1:0] fb_addr_out,
  output logic [15:0]       fb_data_out,
  output logic              fb_we_out,
  output logic              busy_out,
  output logic [15:0]       drop_count_out
);

`ifdef FB_PLOT_CLEAR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_PLOT  = 2'd2
  } state_t;
  localparam state_t c_rst_state = S_IDLE;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLOT  = 2'd2
  } state_t;
  localparam state_t c_rst_state = S_PLOT;
`endif

  localparam logic [15:0]       c_fb_w     = 16'(FB_WIDTH);
  localparam logic [15:0]       c_fb_h     = 16'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] c_w_addr   = ADDR_W'(FB_WIDTH);
  localparam logic [15:0]       c_drop_one = 16'd1;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fb_addr, w_addr_nxt;
  logic [15:0]       r_fb_data, w_data_nxt;
  logic              r_fb_we, w_we_nxt;
  logic [15:0]       r_drop_count, w_drop_nxt;
  logic              w_accept;
  logic              w_in_bounds;
  logic [ADDR_W-1:0] w_pt_addr;

`ifdef FB_PLOT_CLEAR_EN
  // Counter holds the next address to clear; one extra bit so it can reach
  // the full pixel count even when that equals 2**ADDR_W.
  localparam logic [ADDR_W:0] c_total   = (ADDR_W+1)'(FB_WIDTH * FB_HEIGHT);
  localparam logic [ADDR_W:0] c_clr_one = (ADDR_W+1)'(1);
  logic [ADDR_W:0] r_clr_cnt, w_clr_nxt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^CLEAR_COLOR;
`endif

  // Reset gates ready so no beat is taken while the block is held in reset.
  assign ready_out   = (r_state == S_PLOT) && !rst_in;
  assign w_accept    = valid_in && ready_out;
  assign w_in_bounds = (x_in < c_fb_w) && (y_in < c_fb_h);
  assign w_pt_addr   = ADDR_W'(y_in) * c_w_addr + ADDR_W'(x_in);

`ifdef FB_PLOT_CLEAR_EN
  assign busy_out = (r_state == S_CLEAR);
`else
  assign busy_out = 1'b0;
`endif

  assign fb_addr_out    = r_fb_addr;
  assign fb_data_out    = r_fb_data;
  assign fb_we_out      = r_fb_we;
  assign drop_count_out = r_drop_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= c_rst_state;
      r_fb_addr    <= '0;
      r_fb_data    <= '0;
      r_fb_we      <= 1'b0;
      r_drop_count <= '0;
`ifdef FB_PLOT_CLEAR_EN
      r_clr_cnt    <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_fb_addr    <= w_addr_nxt;
      r_fb_data    <= w_data_nxt;
      r_fb_we      <= w_we_nxt;
      r_drop_count <= w_drop_nxt;
`ifdef FB_PLOT_CLEAR_EN
      r_clr_cnt    <= w_clr_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_fb_addr;
    w_data_nxt  = r_fb_data;
    w_drop_nxt  = r_drop_count;
`ifdef FB_PLOT_CLEAR_EN
    w_clr_nxt   = r_clr_cnt;
`endif

    if (frame_start_in) begin
      w_drop_nxt = '0;
    end else if (w_accept && !w_in_bounds && (r_drop_count != 16'hFFFF)) begin
      w_drop_nxt = r_drop_count + c_drop_one;
    end

    case (r_state)
`ifdef FB_PLOT_CLEAR_EN
      S_IDLE: begin
        if (frame_start_in) begin
          w_state_nxt = S_CLEAR;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = '0;
          w_data_nxt  = CLEAR_COLOR;
          w_clr_nxt   = c_clr_one;
        end
      end
      S_CLEAR: begin
        if (frame_start_in) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = '0;
          w_data_nxt  = CLEAR_COLOR;
          w_clr_nxt   = c_clr_one;
        end else if (r_clr_cnt == c_total) begin
          w_state_nxt = S_PLOT;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_clr_cnt[ADDR_W-1:0];
          w_data_nxt  = CLEAR_COLOR;
          w_clr_nxt   = r_clr_cnt + c_clr_one;
        end
      end
`else
      S_IDLE: w_state_nxt = S_PLOT;
`endif
      S_PLOT: begin
        // A beat coinciding with frame start is discarded outright.
        if (frame_start_in) begin
`ifdef FB_PLOT_CLEAR_EN
          w_state_nxt = S_CLEAR;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = '0;
          w_data_nxt  = CLEAR_COLOR;
          w_clr_nxt   = c_clr_one;
`endif
        end else if (w_accept && w_in_bounds) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = w_pt_addr;
          w_data_nxt = color_in;
        end
      end
      default: w_state_nxt = c_rst_state;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_plotter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_plotter
// Purpose  : Directed self-checking bench for fb_plotter (both builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_plotter;

  logic        clk_pixel = 1'b0;
  logic        rst_in;
  logic        frame_start_in;
  logic [15:0] x_in, y_in, color_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] fb_addr_out;
  logic [15:0] fb_data_out;
  logic        fb_we_out;
  logic        busy_out;
  logic [15:0] drop_count_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_pixel = ~clk_pixel;

  fb_plotter dut (
    .clk_in         (clk_pixel),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .x_in           (x_in),
    .y_in           (y_in),
    .color_in       (color_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .fb_addr_out    (fb_addr_out),
    .fb_data_out    (fb_data_out),
    .fb_we_out      (fb_we_out),
    .busy_out       (busy_out),
    .drop_count_out (drop_count_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic beat(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
    x_in = x; y_in = y; color_in = c; valid_in = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(fb_we_out), 32'd0);
    check({tag, "_addr"},  32'(fb_addr_out), 32'd0);
    check({tag, "_data"},  32'(fb_data_out), 32'd0);
    check({tag, "_ready"}, 32'(ready_out), 32'd0);
    check({tag, "_busy"},  32'(busy_out), 32'd0);
    check({tag, "_drop"},  32'(drop_count_out), 32'd0);
  endtask

  initial begin
    int seq_err;
    int n;
    rst_in = 1'b1; frame_start_in = 1'b0; valid_in = 1'b0;
    x_in = '0; y_in = '0; color_in = '0;

    repeat (2) @(posedge clk_pixel);
    #1;
    check_all_zero("reset");
    rst_in = 1'b0;
    #1;

`ifdef FB_PLOT_CLEAR_EN
    check("idle_ready", 32'(ready_out), 32'd0);
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    check("clr_first_we",   32'(fb_we_out), 32'd1);
    check("clr_first_addr", 32'(fb_addr_out), 32'd0);
    check("clr_first_busy", 32'(busy_out), 32'd1);
    check("clr_first_rdy",  32'(ready_out), 32'd0);
    seq_err = 0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (fb_we_out !== 1'b1 || fb_addr_out !== 16'(i) || fb_data_out !== 16'h0000) seq_err++;
    end
    check("clr_pre_restart_seq", 32'(seq_err), 32'd0);
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    check("clr_restart_addr", 32'(fb_addr_out), 32'd0);
    check("clr_restart_we",   32'(fb_we_out), 32'd1);
    n = 1; seq_err = 0;
    for (int k = 0; k < 60000; k++) begin
      step();
      if (!(fb_we_out === 1'b1 && busy_out === 1'b1)) break;
      if (fb_addr_out !== 16'(n) || fb_data_out !== 16'h0000 || ready_out !== 1'b0) seq_err++;
      n++;
    end
    check("clr_sweep_len",  32'(n), 32'd57600);
    check("clr_sweep_seq",  32'(seq_err), 32'd0);
    check("clr_done_we",    32'(fb_we_out), 32'd0);
    check("clr_done_busy",  32'(busy_out), 32'd0);
    check("clr_done_ready", 32'(ready_out), 32'd1);
`else
    check("plot_ready_after_rst", 32'(ready_out), 32'd1);
`endif

    beat(16'd10, 16'd20, 16'hF800);
    step();
    check("p1_we",   32'(fb_we_out), 32'd1);
    check("p1_addr", 32'(fb_addr_out), 32'd6410);
    check("p1_data", 32'(fb_data_out), 32'hF800);
    beat(16'd0, 16'd0, 16'h001F);
    step();
    check("p2_we",   32'(fb_we_out), 32'd1);
    check("p2_addr", 32'(fb_addr_out), 32'd0);
    check("p2_data", 32'(fb_data_out), 32'h001F);
    beat(16'd319, 16'd179, 16'h07E0);
    step();
    check("p3_we",   32'(fb_we_out), 32'd1);
    check("p3_addr", 32'(fb_addr_out), 32'd57599);
    check("p3_data", 32'(fb_data_out), 32'h07E0);
    check("p3_drop", 32'(drop_count_out), 32'd0);
    valid_in = 1'b0;
    step();
    check("idle_we", 32'(fb_we_out), 32'd0);

    beat(16'd320, 16'd0, 16'h1111);
    step();
    check("oob1_we",   32'(fb_we_out), 32'd0);
    check("oob1_drop", 32'(drop_count_out), 32'd1);
    beat(16'd0, 16'd180, 16'h2222);
    step();
    check("oob2_we",   32'(fb_we_out), 32'd0);
    check("oob2_drop", 32'(drop_count_out), 32'd2);
    beat(16'hFFFF, 16'd5, 16'h3333);
    step();
    check("oob3_we",   32'(fb_we_out), 32'd0);
    check("oob3_drop", 32'(drop_count_out), 32'd3);

    beat(16'd5, 16'd5, 16'hFFFF);
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    valid_in = 1'b0;
    check("sim_drop", 32'(drop_count_out), 32'd0);
`ifdef FB_PLOT_CLEAR_EN
    check("sim_we",   32'(fb_we_out), 32'd1);
    check("sim_addr", 32'(fb_addr_out), 32'd0);
    check("sim_data", 32'(fb_data_out), 32'h0000);
    check("sim_busy", 32'(busy_out), 32'd1);
`else
    check("sim_we",   32'(fb_we_out), 32'd0);
`endif

    beat(16'd2, 16'd2, 16'hAAAA);
    step();
`ifdef FB_PLOT_CLEAR_EN
    check("pend_addr", 32'(fb_addr_out), 32'd1);
    check("pend_busy", 32'(busy_out), 32'd1);
`else
    check("pend_we",   32'(fb_we_out), 32'd1);
    check("pend_addr", 32'(fb_addr_out), 32'd642);
    check("pend_data", 32'(fb_data_out), 32'hAAAA);
`endif
    valid_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    check_all_zero("async_rst");
    step();
    rst_in = 1'b0;
    #1;
`ifdef FB_PLOT_CLEAR_EN
    check("post_rst_ready", 32'(ready_out), 32'd0);
`else
    check("post_rst_ready", 32'(ready_out), 32'd1);
`endif
    beat(16'd1, 16'd0, 16'h1234);
    step();
    valid_in = 1'b0;
`ifdef FB_PLOT_CLEAR_EN
    check("post_rst_we",   32'(fb_we_out), 32'd0);
    check("post_rst_busy", 32'(busy_out), 32'd0);
    step();
    check("post_rst_idle", 32'(ready_out), 32'd0);
`else
    check("post_rst_we",   32'(fb_we_out), 32'd1);
    check("post_rst_addr", 32'(fb_addr_out), 32'd1);
    check("post_rst_data", 32'(fb_data_out), 32'h1234);
    step();
    check("post_rst_done", 32'(fb_we_out), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
